// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: state encoding and default sizes.
package div_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;
endpackage

// File: rtl/seq_divider32_if.sv
// Request/response bundle between a controller (master) and the divider (slave).
interface seq_divider32_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference if it did not borrow.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_prem,
  input  logic             i_qmsb,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_prem,
  output logic             o_qbit
);
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_trial;

  assign w_shift = {i_prem, i_qmsb};
  assign w_trial = w_shift - {1'b0, i_divisor};
  assign o_qbit  = ~w_trial[WIDTH];
  // The selected partial remainder is always below the divisor, so its top bit is zero.
  assign o_prem  = o_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
endmodule

// File: rtl/seq_divider32.sv
// Multi-cycle restoring divider, one quotient bit per clock, WIDTH steps per divide.
// Define DIVIDER_SIGNED_EN to build two's-complement operand/result sign handling.
module seq_divider32
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic           clk,
  input  logic           reset,
  seq_divider32_if.slave bus
);
  div_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_prem;
  logic [WIDTH-1:0] r_qsr;
  logic [WIDTH-1:0] r_dvsr;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;

  logic             w_accept;
  logic             w_zero;
  logic             w_last;
  logic [WIDTH-1:0] w_prem_nxt;
  logic             w_qbit;
  logic [WIDTH-1:0] w_uq;
  logic [WIDTH-1:0] w_op_a, w_op_b, w_q_fix, w_r_fix;

  assign w_accept = bus.start && (r_state == DIV_IDLE || r_state == DIV_DONE);
  assign w_zero   = (bus.divisor == '0);
  assign w_last   = (r_cnt == CNT_W'(WIDTH-1));

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_prem    (r_prem),
    .i_qmsb    (r_qsr[WIDTH-1]),
    .i_divisor (r_dvsr),
    .o_prem    (w_prem_nxt),
    .o_qbit    (w_qbit)
  );

  assign w_uq = {r_qsr[WIDTH-2:0], w_qbit};

`ifdef DIVIDER_SIGNED_EN
  logic r_neg_q, r_neg_r;

  assign w_op_a  = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
  assign w_op_b  = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
  // MIN/-1 falls out naturally: magnitude 2**(WIDTH-1) negated wraps to itself.
  assign w_q_fix = r_neg_q ? -w_uq : w_uq;
  assign w_r_fix = r_neg_r ? -w_prem_nxt : w_prem_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_neg_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
      r_neg_r <= bus.dividend[WIDTH-1];
    end
  end
`else
  assign w_op_a  = bus.dividend;
  assign w_op_b  = bus.divisor;
  assign w_q_fix = w_uq;
  assign w_r_fix = w_prem_nxt;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DIV_IDLE, DIV_DONE:
        w_state_nxt = bus.start ? (w_zero ? DIV_DONE : DIV_RUN) : DIV_IDLE;
      DIV_RUN:
        if (w_last) w_state_nxt = DIV_DONE;
      default:
        w_state_nxt = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= DIV_IDLE;
      r_cnt   <= '0;
      r_prem  <= '0;
      r_qsr   <= '0;
      r_dvsr  <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_prem <= '0;
        r_qsr  <= w_op_a;
        r_dvsr <= w_op_b;
        r_cnt  <= '0;
        r_dbz  <= w_zero;
        // Zero divisor skips RUN; the raw dividend is returned as the remainder.
        if (w_zero) begin
          r_quot <= '1;
          r_rem  <= bus.dividend;
        end
      end else if (r_state == DIV_RUN) begin
        r_prem <= w_prem_nxt;
        r_qsr  <= w_uq;
        r_cnt  <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_quot <= w_q_fix;
          r_rem  <= w_r_fix;
        end
      end
    end
  end

  assign bus.busy        = (r_state == DIV_RUN);
  assign bus.done        = (r_state == DIV_DONE);
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_rem;
  assign bus.div_by_zero = r_dbz;
endmodule
